// File: rtl/round_controller.sv
// round_controller: sequencer for one round of the keyboard reaction game.
// Draws a goal letter from a 5-bit LFSR, runs and freezes the reaction timer,
// judges the first key press of the round (hit, miss or timeout), selects the
// seven-segment display source and keeps a saturating win count.
module round_controller #(
  parameter int unsigned LETTER_COUNT  = 20,
  parameter logic [4:0]  KEY_RELEASE   = 5'd21,
  parameter int unsigned TIMEOUT_TICKS = 40,
  parameter int unsigned HOLD_TICKS    = 8,
  parameter logic [4:0]  LFSR_SEED     = 5'h1B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key_code,
  input  logic       tick,
  output logic [1:0] timer_ctl,
  output logic [4:0] goal_letter,
  output logic [1:0] disp_sel,
  output logic       round_win,
  output logic       round_loss,
  output logic       timed_out,
  output logic [7:0] score
);

  localparam int unsigned TOW = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned HW  = $clog2(HOLD_TICKS + 1);

  localparam logic [4:0]     LC       = 5'(LETTER_COUNT);
  localparam logic [4:0]     LC_LAST  = 5'(LETTER_COUNT - 1);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_TICKS - 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_TICKS);

  // Timer control encodings: MSB enable, LSB clear.
  localparam logic [1:0] TC_CLEAR  = 2'b01;
  localparam logic [1:0] TC_RUN    = 2'b10;
  localparam logic [1:0] TC_FREEZE = 2'b00;

  // Display source encodings.
  localparam logic [1:0] DS_BLANK = 2'd0;
  localparam logic [1:0] DS_GOAL  = 2'd1;
  localparam logic [1:0] DS_TIME  = 2'd2;
  localparam logic [1:0] DS_LOSS  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_WIN,
    S_LOSS
  } state_t;

  state_t state_q, state_d;

  logic [4:0]     last_key;
  logic [4:0]     lfsr_q;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;

  logic key_evt, press_evt, rel_evt, hold_done, hit;

  logic [4:0] cand, goal_pick, goal_d;
  logic [7:0] score_d;
  logic       win_d, loss_d, timed_out_d;
  logic [1:0] disp_d, tctl_d;

  // Key event detection against the previous cycle's code.
  assign key_evt   = (key_code != last_key);
  assign press_evt = key_evt && (key_code != KEY_RELEASE);
  assign rel_evt   = key_evt && (key_code == KEY_RELEASE);
  assign hold_done = (hold_cnt_q == HOLD_MAX);
  assign hit       = (key_code == goal_letter);

  // Previous key code and free-running x^5+x^3+1 LFSR (never reaches zero).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_key <= KEY_RELEASE;
      lfsr_q   <= LFSR_SEED;
    end else begin
      last_key <= key_code;
      lfsr_q   <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    end
  end

  // Fold the LFSR value into the letter range and avoid repeating the goal.
  always_comb begin
    if (lfsr_q <= LC) begin
      cand = lfsr_q - 5'd1;
    end else begin
      cand = lfsr_q - 5'd1 - LC;
    end
    goal_pick = cand;
    if (cand == goal_letter) begin
      goal_pick = (cand == LC_LAST) ? '0 : cand + 5'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counters and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    goal_d      = goal_letter;
    score_d     = score;
    win_d       = 1'b0;
    loss_d      = 1'b0;
    timed_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rel_evt) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        goal_d   = goal_pick;
        to_cnt_d = '0;
        state_d  = S_PLAY;
      end

      S_PLAY: begin
        if (tick) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        // A press in the same cycle as the timeout tick wins the tie.
        if (press_evt) begin
          hold_cnt_d = '0;
          if (hit) begin
            state_d = S_WIN;
            win_d   = 1'b1;
            if (score != '1) begin
              score_d = score + 8'd1;
            end
          end else begin
            state_d = S_LOSS;
            loss_d  = 1'b1;
          end
        end else if (tick && (to_cnt_q == TO_LAST)) begin
          hold_cnt_d  = '0;
          state_d     = S_LOSS;
          loss_d      = 1'b1;
          timed_out_d = 1'b1;
        end
      end

      S_WIN, S_LOSS: begin
        if (tick && !hold_done) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (state_q == S_LOSS) begin
          timed_out_d = timed_out;
        end
        if (rel_evt && hold_done) begin
          state_d     = S_LOAD;
          timed_out_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Display and timer control follow the state being entered.
    case (state_d)
      S_PLAY: begin
        disp_d = DS_GOAL;
        tctl_d = TC_RUN;
      end
      S_WIN: begin
        disp_d = DS_TIME;
        tctl_d = TC_FREEZE;
      end
      S_LOSS: begin
        disp_d = DS_LOSS;
        tctl_d = TC_FREEZE;
      end
      default: begin
        disp_d = DS_BLANK;
        tctl_d = TC_CLEAR;
      end
    endcase
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      goal_letter <= '0;
      score       <= '0;
      round_win   <= 1'b0;
      round_loss  <= 1'b0;
      timed_out   <= 1'b0;
      disp_sel    <= DS_BLANK;
      timer_ctl   <= TC_CLEAR;
    end else begin
      to_cnt_q    <= to_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      goal_letter <= goal_d;
      score       <= score_d;
      round_win   <= win_d;
      round_loss  <= loss_d;
      timed_out   <= timed_out_d;
      disp_sel    <= disp_d;
      timer_ctl   <= tctl_d;
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: randomized rounds against a behavioural game model,
// with round results checked through a scoreboard queue by a monitor.
module tb_round_controller;

  localparam int         LETTER_COUNT  = 20;
  localparam logic [4:0] KEY_RELEASE   = 5'd21;
  localparam int         TIMEOUT_TICKS = 40;
  localparam int         HOLD_TICKS    = 8;
  localparam logic [4:0] LFSR_SEED     = 5'h1B;

  logic       clk;
  logic       rst_n;
  logic [4:0] key_code;
  logic       tick;
  logic [1:0] timer_ctl;
  logic [4:0] goal_letter;
  logic [1:0] disp_sel;
  logic       round_win;
  logic       round_loss;
  logic       timed_out;
  logic [7:0] score;

  round_controller #(
    .LETTER_COUNT (LETTER_COUNT),
    .KEY_RELEASE  (KEY_RELEASE),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .HOLD_TICKS   (HOLD_TICKS),
    .LFSR_SEED    (LFSR_SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .tick       (tick),
    .timer_ctl  (timer_ctl),
    .goal_letter(goal_letter),
    .disp_sel   (disp_sel),
    .round_win  (round_win),
    .round_loss (round_loss),
    .timed_out  (timed_out),
    .score      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          win;
    bit          to;
    int          score;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          ref_lfsr;
  int          prev_goal = 0;
  int          exp_score = 0;
  bit          prev_pulse;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, req, $time);
    end
  endtask

  // Reference sequence: x^5+x^3+1, new bit from stages 5 and 3 shifted in low.
  function automatic int lfsr_next(input int v);
    return ((v * 2) % 32) + (((v / 16) + (v / 4)) % 2);
  endfunction

  function automatic int pick_goal(input int v, input int prev);
    int c;
    c = (v <= LETTER_COUNT) ? v - 1 : v - 1 - LETTER_COUNT;
    if (c == prev) c = (c + 1) % LETTER_COUNT;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= int'(LFSR_SEED);
    else        ref_lfsr <= lfsr_next(ref_lfsr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse <= 1'b0;
    end else begin
      prev_pulse <= round_win | round_loss;
      if (prev_pulse) check("pulse_width", int'(round_win | round_loss), 0);
      if (round_win || round_loss) begin
        if (sbq.size() == 0) begin
          check("unexpected_pulse", int'({round_win, round_loss}), 0);
        end else begin
          check("result_cycle", int'(cyc), int'(sbq[0].cyc));
          check("result_win", int'(round_win), int'(sbq[0].win));
          check("result_loss", int'(round_loss), int'(!sbq[0].win));
          check("result_timed_out", int'(timed_out), int'(sbq[0].to));
          check("result_score", int'(score), sbq[0].score);
          check("result_disp", int'(disp_sel), sbq[0].win ? 2 : 3);
          check("result_timer", int'(timer_ctl), 0);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input bit w, input bit t);
    sbq.push_back('{win: w, to: t, score: exp_score, cyc: cyc + 1});
  endtask

  task automatic pulse_tick(input bit arm_timeout);
    @(negedge clk);
    if (arm_timeout) push_exp(1'b0, 1'b1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_tick(1'b0);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
  endtask

  task automatic press(input logic [4:0] code, input bit with_tick, input bit win);
    @(negedge clk);
    if (win) exp_score = (exp_score < 255) ? exp_score + 1 : 255;
    push_exp(win, 1'b0);
    key_code = code;
    tick     = with_tick;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Release (after a press if needed) and check the LOAD -> PLAY handover.
  task automatic start_round();
    int eg;
    @(negedge clk);
    if (key_code == KEY_RELEASE) begin
      key_code = 5'd5;
      @(negedge clk);
    end
    key_code = KEY_RELEASE;
    @(posedge clk);
    #1;
    check("load_timer_clear", int'(timer_ctl), 1);
    eg = pick_goal(ref_lfsr, prev_goal);
    @(posedge clk);
    #1;
    check("goal_letter", int'(goal_letter), eg);
    check("goal_range", int'(goal_letter < LETTER_COUNT), 1);
    check("goal_changed", int'(int'(goal_letter) != prev_goal), 1);
    check("play_timer_run", int'(timer_ctl), 2);
    check("play_disp", int'(disp_sel), 1);
    check("play_timed_out", int'(timed_out), 0);
    prev_goal = eg;
  endtask

  function automatic logic [4:0] wrong_code();
    logic [4:0] c;
    do c = 5'($urandom_range(0, 31));
    while (int'(c) == prev_goal || c == KEY_RELEASE);
    return c;
  endfunction

  // kind: 0 hit, 1 miss, 2 timeout, 3 hit on the timeout tick.
  task automatic play_round(input int kind);
    case (kind)
      0: begin ticks($urandom_range(0, 5)); press(5'(prev_goal), 1'b0, 1'b1); end
      1: begin ticks($urandom_range(0, 5)); press(wrong_code(), 1'b0, 1'b0); end
      2: begin
        for (int i = 1; i <= TIMEOUT_TICKS; i++) begin
          pulse_tick(i == TIMEOUT_TICKS);
          if (i < TIMEOUT_TICKS) repeat ($urandom_range(0, 1)) @(negedge clk);
        end
      end
      default: begin ticks(TIMEOUT_TICKS - 1); press(5'(prev_goal), 1'b1, 1'b1); end
    endcase
    repeat (HOLD_TICKS) pulse_tick(1'b0);
    check("hold_timed_out", int'(timed_out), (kind == 2) ? 1 : 0);
    check("hold_disp", int'(disp_sel), (kind == 1 || kind == 2) ? 3 : 2);
    check("hold_timer", int'(timer_ctl), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    key_code = KEY_RELEASE;
    tick     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_timer", int'(timer_ctl), 1);
    check("rst_disp", int'(disp_sel), 0);
    check("rst_score", int'(score), 0);
    check("rst_goal", int'(goal_letter), 0);
    check("rst_pulses", int'({round_win, round_loss, timed_out}), 0);
    repeat (2) @(negedge clk);
    check("idle_timer", int'(timer_ctl), 1);

    // Hit, then a release at hold tick 3 that must be ignored.
    start_round();
    press(5'(prev_goal), 1'b0, 1'b1);
    repeat (3) pulse_tick(1'b0);
    @(negedge clk);
    key_code = KEY_RELEASE;
    @(posedge clk);
    #1;
    check("early_release_timer", int'(timer_ctl), 0);
    check("early_release_disp", int'(disp_sel), 2);
    repeat (HOLD_TICKS - 3) pulse_tick(1'b0);

    // Directed miss, timeout and press-on-timeout-tick.
    start_round(); play_round(1);
    start_round(); play_round(2);
    start_round(); play_round(3);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      start_round();
      play_round($urandom_range(0, 3));
    end

    // Saturate the score.
    for (int r = 0; r < 256; r++) begin
      start_round();
      press(5'(prev_goal), 1'b0, 1'b1);
      repeat (HOLD_TICKS) pulse_tick(1'b0);
    end
    check("score_saturated", int'(score), 255);

    // Asynchronous reset in the middle of PLAY.
    start_round();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_timer", int'(timer_ctl), 1);
    check("arst_disp", int'(disp_sel), 0);
    check("arst_goal", int'(goal_letter), 0);
    check("arst_score", int'(score), 0);
    check("arst_pulses", int'({round_win, round_loss, timed_out}), 0);
    exp_score = 0;
    prev_goal = 0;
    key_code  = KEY_RELEASE;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_timer", int'(timer_ctl), 1);
    check("post_rst_idle_disp", int'(disp_sel), 0);
    start_round();
    play_round(0);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
